regfile_arbiter: RTL and testbench

Two-port round-robin arbiter and clear sequencer for the 16 x 8-bit register-file memory. It multiplexes two independent requesters onto the memory's single write-enable/select/data port. It returns read data to the requester that issued the read. After reset, or on command, it sweeps every location to a constant before any requester is served.

---
 rtl/regfile_arbiter_if.sv | 36 +++
 rtl/regfile_arbiter.sv | 102 ++++++++++
 tb/tb_regfile_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_arbiter_if.sv
// Requester and memory-port bundle for the register-file arbiter.
// Handshake: a requester holds req/we/addr/wdata stable until it sees gnt high
// in the same cycle; gnt means the transaction is issued that cycle, and a read
// returns rvalid/rdata exactly one cycle later.
interface regfile_arbiter_if;
  logic       req0;
  logic       req1;
  logic       we0;
  logic       we1;
  logic [3:0] addr0;
  logic [3:0] addr1;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic       gnt0;
  logic       gnt1;
  logic       rvalid0;
  logic       rvalid1;
  logic [7:0] rdata0;
  logic [7:0] rdata1;
  logic       mem_we;
  logic [3:0] mem_regsel;
  logic [7:0] mem_datatowrite;
  logic [7:0] mem_readdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_readdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_we, mem_regsel, mem_datatowrite
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_readdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_we, mem_regsel, mem_datatowrite
  );
endinterface

// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter for a 16 x 8 register file, with a
// full-memory clear sweep after reset or on a clr_start pulse.
module regfile_arbiter #(
  parameter logic [7:0] CLEAR_VAL = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_start,
  output logic               clr_busy,
  output logic               o_dbg_state,
  regfile_arbiter_if.slave   bus
);

  typedef enum logic {S_SERVE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_last;
  logic       r_rvalid0;
  logic       r_rvalid1;

  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_mem_we;
  logic [3:0] w_mem_regsel;
  logic [7:0] w_mem_data;

  // r_last = 1 means requester 1 was served most recently, so 0 wins a tie.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst && r_state == S_SERVE) begin
      if (bus.req0 && bus.req1) begin
        w_gnt0 = r_last;
        w_gnt1 = ~r_last;
      end else begin
        w_gnt0 = bus.req0;
        w_gnt1 = bus.req1;
      end
    end
  end

  always_comb begin
    w_mem_we     = 1'b0;
    w_mem_regsel = 4'd0;
    w_mem_data   = 8'h00;
    if (!rst && r_state == S_CLEAR) begin
      w_mem_we     = 1'b1;
      w_mem_regsel = r_cnt;
      w_mem_data   = CLEAR_VAL;
    end else if (w_gnt0) begin
      w_mem_we     = bus.we0;
      w_mem_regsel = bus.addr0;
      w_mem_data   = bus.wdata0;
    end else if (w_gnt1) begin
      w_mem_we     = bus.we1;
      w_mem_regsel = bus.addr1;
      w_mem_data   = bus.wdata1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_CLEAR;
      r_cnt     <= 4'd0;
      r_last    <= 1'b1;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_gnt0 & ~bus.we0;
      r_rvalid1 <= w_gnt1 & ~bus.we1;
      case (r_state)
        S_CLEAR: begin
          // Counter wraps to 0 on the last sweep cycle, ready for the next sweep.
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) r_state <= S_SERVE;
        end
        default: begin
          if (w_gnt0) r_last <= 1'b0;
          if (w_gnt1) r_last <= 1'b1;
          if (clr_start) begin
            r_state <= S_CLEAR;
            r_cnt   <= 4'd0;
          end
        end
      endcase
    end
  end

  assign clr_busy            = rst || (r_state == S_CLEAR);
  assign o_dbg_state         = r_state;
  assign bus.gnt0            = w_gnt0;
  assign bus.gnt1            = w_gnt1;
  assign bus.rvalid0         = r_rvalid0;
  assign bus.rvalid1         = r_rvalid1;
  assign bus.rdata0          = bus.mem_readdata;
  assign bus.rdata1          = bus.mem_readdata;
  assign bus.mem_we          = w_mem_we;
  assign bus.mem_regsel      = w_mem_regsel;
  assign bus.mem_datatowrite = w_mem_data;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: sweep, arbitration, read return, clear and reset.
module tb_regfile_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_start = 1'b0;
  logic clr_busy;
  logic dbg_state;
  int   checks = 0;
  int   errors = 0;

  regfile_arbiter_if bus();

  regfile_arbiter #(.CLEAR_VAL(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .clr_start   (clr_start),
    .clr_busy    (clr_busy),
    .o_dbg_state (dbg_state),
    .bus         (bus.slave)
  );

  always #5 clk = ~clk;

  // Register-file model: synchronous write, one-cycle registered read.
  logic [7:0] mem_arr [16];
  always @(posedge clk) begin
    if (bus.mem_we) mem_arr[bus.mem_regsel] <= bus.mem_datatowrite;
    bus.mem_readdata <= mem_arr[bus.mem_regsel];
  end

  function automatic logic [14:0] port_vec();
    return {bus.gnt0, bus.gnt1, bus.mem_we, bus.mem_regsel, bus.mem_datatowrite};
  endfunction

  task automatic idle_reqs();
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 4'd0; bus.wdata0 = 8'h00;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 4'd0; bus.wdata1 = 8'h00;
  endtask

  task automatic test_reset();
    logic [3:0] kk;
    idle_reqs();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd7; bus.wdata0 = 8'hEE;
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (port_vec() !== 15'h0 || clr_busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_hold got vec=%h busy=%b want vec=0000 busy=1", port_vec(), clr_busy);
    end
    checks++;
    if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0 || dbg_state !== 1'b1) begin
      errors++;
      $display("FAIL rst_state got rv0=%b rv1=%b st=%b want 0 0 1", bus.rvalid0, bus.rvalid1, dbg_state);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      kk = k[3:0];
      #1;
      checks++;
      if (port_vec() !== {1'b0, 1'b0, 1'b1, kk, 8'h00} || clr_busy !== 1'b1) begin
        errors++;
        $display("FAIL sweep[%0d] got vec=%h busy=%b want vec=%h busy=1", k, port_vec(), clr_busy,
                 {1'b0, 1'b0, 1'b1, kk, 8'h00});
      end
      @(negedge clk);
    end
    idle_reqs();
    #1;
    checks++;
    if (port_vec() !== 15'h0 || clr_busy !== 1'b0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL post_sweep got vec=%h busy=%b st=%b want 0000 0 0", port_vec(), clr_busy, dbg_state);
    end
    @(negedge clk);
  endtask

  task automatic test_conflict();
    logic [14:0] exp;
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd5; bus.wdata0 = 8'h55;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 4'd6; bus.wdata1 = 8'h66;
    for (int k = 0; k < 4; k++) begin
      exp = (k % 2 == 0) ? {1'b1, 1'b0, 1'b1, 4'd5, 8'h55} : {1'b0, 1'b1, 1'b1, 4'd6, 8'h66};
      #1;
      checks++;
      if (port_vec() !== exp) begin
        errors++;
        $display("FAIL conflict[%0d] got %h want %h", k, port_vec(), exp);
      end
      @(negedge clk);
    end
    idle_reqs();
  endtask

  task automatic test_single();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd3; bus.wdata0 = 8'hA5;
    #1;
    checks++;
    if (port_vec() !== {1'b1, 1'b0, 1'b1, 4'd3, 8'hA5}) begin
      errors++;
      $display("FAIL single_wr got %h want %h", port_vec(), {1'b1, 1'b0, 1'b1, 4'd3, 8'hA5});
    end
    @(negedge clk);
    bus.we0 = 1'b0;
    #1;
    checks++;
    if (port_vec() !== {1'b1, 1'b0, 1'b0, 4'd3, 8'hA5} || bus.rvalid0 !== 1'b0) begin
      errors++;
      $display("FAIL single_rd got vec=%h rv0=%b want %h rv0=0", port_vec(), bus.rvalid0,
               {1'b1, 1'b0, 1'b0, 4'd3, 8'hA5});
    end
    @(negedge clk);
    idle_reqs();
    #1;
    checks++;
    if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 8'hA5 || bus.rvalid1 !== 1'b0) begin
      errors++;
      $display("FAIL single_rvalid got rv0=%b rd0=%h rv1=%b want 1 a5 0", bus.rvalid0, bus.rdata0, bus.rvalid1);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.rvalid0 !== 1'b0) begin
      errors++;
      $display("FAIL single_rvalid_pulse got rv0=%b want 0", bus.rvalid0);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 4'd1; bus.wdata0 = 8'h11;
    #1;
    checks++;
    if (port_vec() !== {1'b1, 1'b0, 1'b1, 4'd1, 8'h11}) begin
      errors++;
      $display("FAIL b2b_wr1 got %h want %h", port_vec(), {1'b1, 1'b0, 1'b1, 4'd1, 8'h11});
    end
    @(negedge clk);
    idle_reqs();
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 4'd2; bus.wdata1 = 8'h22;
    #1;
    checks++;
    if (port_vec() !== {1'b0, 1'b1, 1'b1, 4'd2, 8'h22}) begin
      errors++;
      $display("FAIL b2b_wr2 got %h want %h", port_vec(), {1'b0, 1'b1, 1'b1, 4'd2, 8'h22});
    end
    @(negedge clk);
    idle_reqs();
    bus.req0 = 1'b1; bus.addr0 = 4'd1;
    bus.req1 = 1'b1; bus.addr1 = 4'd2;
    #1;
    checks++;
    if (port_vec() !== {1'b1, 1'b0, 1'b0, 4'd1, 8'h00}) begin
      errors++;
      $display("FAIL b2b_rd0 got %h want %h", port_vec(), {1'b1, 1'b0, 1'b0, 4'd1, 8'h00});
    end
    @(negedge clk);
    bus.req0 = 1'b0;
    #1;
    checks++;
    if (port_vec() !== {1'b0, 1'b1, 1'b0, 4'd2, 8'h00} || bus.rvalid0 !== 1'b1 || bus.rdata0 !== 8'h11) begin
      errors++;
      $display("FAIL b2b_rd1 got vec=%h rv0=%b rd0=%h want %h 1 11", port_vec(), bus.rvalid0, bus.rdata0,
               {1'b0, 1'b1, 1'b0, 4'd2, 8'h00});
    end
    @(negedge clk);
    idle_reqs();
    #1;
    checks++;
    if (bus.rvalid1 !== 1'b1 || bus.rdata1 !== 8'h22 || bus.rvalid0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_rvalid1 got rv1=%b rd1=%h rv0=%b want 1 22 0", bus.rvalid1, bus.rdata1, bus.rvalid0);
    end
    @(negedge clk);
  endtask

  task automatic test_clear_pending();
    logic [3:0] kk;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 4'd3;
    clr_start = 1'b1;
    #1;
    checks++;
    if (port_vec() !== {1'b1, 1'b0, 1'b0, 4'd3, 8'h00} || clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_grant got vec=%h busy=%b want %h 0", port_vec(), clr_busy,
               {1'b1, 1'b0, 1'b0, 4'd3, 8'h00});
    end
    @(negedge clk);
    idle_reqs();
    clr_start = 1'b0;
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 4'd9; bus.wdata1 = 8'h99;
    #1;
    checks++;
    if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 8'hA5 || port_vec() !== {1'b0, 1'b0, 1'b1, 4'd0, 8'h00}
        || clr_busy !== 1'b1) begin
      errors++;
      $display("FAIL clr_pending got rv0=%b rd0=%h vec=%h busy=%b want 1 a5 %h 1", bus.rvalid0, bus.rdata0,
               port_vec(), clr_busy, {1'b0, 1'b0, 1'b1, 4'd0, 8'h00});
    end
    @(negedge clk);
    for (int k = 1; k < 16; k++) begin
      kk = k[3:0];
      clr_start = (k == 5);
      #1;
      checks++;
      if (port_vec() !== {1'b0, 1'b0, 1'b1, kk, 8'h00} || clr_busy !== 1'b1) begin
        errors++;
        $display("FAIL clr_sweep[%0d] got vec=%h busy=%b want %h 1", k, port_vec(), clr_busy,
                 {1'b0, 1'b0, 1'b1, kk, 8'h00});
      end
      @(negedge clk);
    end
    clr_start = 1'b0;
    idle_reqs();
    #1;
    checks++;
    if (clr_busy !== 1'b0 || port_vec() !== 15'h0) begin
      errors++;
      $display("FAIL clr_done got busy=%b vec=%h want 0 0000", clr_busy, port_vec());
    end
    @(negedge clk);
    bus.req0 = 1'b1; bus.addr0 = 4'd3;
    #1;
    checks++;
    if (port_vec() !== {1'b1, 1'b0, 1'b0, 4'd3, 8'h00}) begin
      errors++;
      $display("FAIL clr_readback_gnt got %h want %h", port_vec(), {1'b1, 1'b0, 1'b0, 4'd3, 8'h00});
    end
    @(negedge clk);
    idle_reqs();
    #1;
    checks++;
    if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 8'h00) begin
      errors++;
      $display("FAIL clr_readback got rv0=%b rd0=%h want 1 00", bus.rvalid0, bus.rdata0);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midsweep();
    logic [3:0] kk;
    clr_start = 1'b1;
    #1;
    checks++;
    if (clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_start got busy=%b want 0", clr_busy);
    end
    @(negedge clk);
    clr_start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      kk = k[3:0];
      #1;
      checks++;
      if (port_vec() !== {1'b0, 1'b0, 1'b1, kk, 8'h00}) begin
        errors++;
        $display("FAIL mid_pre[%0d] got %h want %h", k, port_vec(), {1'b0, 1'b0, 1'b1, kk, 8'h00});
      end
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (port_vec() !== 15'h0 || clr_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst got vec=%h busy=%b want 0000 1", port_vec(), clr_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      kk = k[3:0];
      #1;
      checks++;
      if (port_vec() !== {1'b0, 1'b0, 1'b1, kk, 8'h00} || clr_busy !== 1'b1) begin
        errors++;
        $display("FAIL mid_restart[%0d] got vec=%h busy=%b want %h 1", k, port_vec(), clr_busy,
                 {1'b0, 1'b0, 1'b1, kk, 8'h00});
      end
      @(negedge clk);
    end
    bus.req0 = 1'b1; bus.addr0 = 4'd4;
    bus.req1 = 1'b1; bus.addr1 = 4'd4;
    #1;
    checks++;
    if (port_vec() !== {1'b1, 1'b0, 1'b0, 4'd4, 8'h00} || clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_last_reset got vec=%h busy=%b want %h 0", port_vec(), clr_busy,
               {1'b1, 1'b0, 1'b0, 4'd4, 8'h00});
    end
    @(negedge clk);
    idle_reqs();
    #1;
    checks++;
    if (bus.rvalid0 !== 1'b1 || bus.rdata0 !== 8'h00 || bus.rvalid1 !== 1'b0) begin
      errors++;
      $display("FAIL mid_read got rv0=%b rd0=%h rv1=%b want 1 00 0", bus.rvalid0, bus.rdata0, bus.rvalid1);
    end
    @(negedge clk);
  endtask

  initial begin
    idle_reqs();
    test_reset();
    test_conflict();
    test_single();
    test_back_to_back();
    test_clear_pending();
    test_reset_midsweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
